// File: rtl/regfile_multi.sv
// regfile_multi: parametrised register file with two registered read ports
// (src, dst), one write port, a gated transfer port (out), and dedicated
// PC / SP registers that are incremented or decremented in place.
//
// Optional build macro REGFILE_BYPASS_EN: when defined, src/dst/out capture
// the value a register takes at this edge (write data, PC+1, SP+/-1) instead
// of its current contents. When undefined, reads return the old value and
// no forwarding path is built.
module regfile_multi #(
  parameter int              WIDTH    = 16,
  parameter int              DEPTH    = 8,
  parameter int              PC_IDX   = 0,
  parameter int              SP_IDX   = 1,
  parameter logic [WIDTH-1:0] SP_RESET = {WIDTH{1'b1}},
  localparam int             AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    src_sel,
  input  logic [AW-1:0]    dst_sel,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pc_inc,
  input  logic             sp_inc,
  input  logic             sp_dec,
  input  logic             out_en,
  output logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] dst,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] sp
);

  logic [WIDTH-1:0] regs     [DEPTH];
  logic [WIDTH-1:0] regs_nxt [DEPTH];
  logic             wr_pc;
  logic             wr_sp;

  // Modulo-2^WIDTH step helpers: all-ones + 1 wraps to 0, 0 - 1 wraps to all-ones.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
    return v - WIDTH'(1);
  endfunction

  assign wr_pc = wr_en && (wr_sel == AW'(PC_IDX));
  assign wr_sp = wr_en && (wr_sel == AW'(SP_IDX));

  // Next-state of every register: an explicit write wins over PC/SP stepping;
  // simultaneous SP inc and dec cancel out.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_nxt[i] = regs[i];
      if (wr_en && (wr_sel == AW'(i))) begin
        regs_nxt[i] = wr_data;
      end
    end
    if (!wr_pc && pc_inc) begin
      regs_nxt[PC_IDX] = wrap_inc(regs[PC_IDX]);
    end
    if (!wr_sp && (sp_inc != sp_dec)) begin
      regs_nxt[SP_IDX] = sp_inc ? wrap_inc(regs[SP_IDX]) : wrap_dec(regs[SP_IDX]);
    end
  end

  // Register array: reset clears all but SP, otherwise commit next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= regs_nxt[i];
      end
    end
  end

  // Registered read and transfer ports; out holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
`ifdef REGFILE_BYPASS_EN
      src <= regs_nxt[src_sel];
      dst <= regs_nxt[dst_sel];
      if (out_en) begin
        out <= regs_nxt[src_sel];
      end
`else
      src <= regs[src_sel];
      dst <= regs[dst_sel];
      if (out_en) begin
        out <= regs[src_sel];
      end
`endif
      out_valid <= out_en;
    end
  end

  assign pc = regs[PC_IDX];
  assign sp = regs[SP_IDX];

endmodule

// File: tb/tb_regfile_multi.sv
// Directed bench for regfile_multi: a 16-bit/8-entry instance and a
// 32-bit/16-entry instance, with hand-computed expected values.
module tb_regfile_multi;

  logic        clk;
  int          n_vec;
  int          n_err;

  // 16-bit, 8-register instance
  logic        rst;
  logic [2:0]  src_sel, dst_sel, wr_sel;
  logic        wr_en, pc_inc, sp_inc, sp_dec, out_en;
  logic [15:0] wr_data;
  logic [15:0] src, dst, out, pc, sp;
  logic        out_valid;

  // 32-bit, 16-register instance
  logic        b_rst;
  logic [3:0]  b_src_sel, b_dst_sel, b_wr_sel;
  logic        b_wr_en, b_pc_inc, b_sp_inc, b_sp_dec, b_out_en;
  logic [31:0] b_wr_data;
  logic [31:0] b_src, b_dst, b_out, b_pc, b_sp;
  logic        b_out_valid;

  regfile_multi dut (
    .clk(clk), .rst(rst), .src_sel(src_sel), .dst_sel(dst_sel),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec), .out_en(out_en),
    .src(src), .dst(dst), .out(out), .out_valid(out_valid), .pc(pc), .sp(sp)
  );

  regfile_multi #(.WIDTH(32), .DEPTH(16)) dut_w (
    .clk(clk), .rst(b_rst), .src_sel(b_src_sel), .dst_sel(b_dst_sel),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
    .pc_inc(b_pc_inc), .sp_inc(b_sp_inc), .sp_dec(b_sp_dec), .out_en(b_out_en),
    .src(b_src), .dst(b_dst), .out(b_out), .out_valid(b_out_valid), .pc(b_pc), .sp(b_sp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    wr_en = 0; pc_inc = 0; sp_inc = 0; sp_dec = 0; out_en = 0;
  endtask

  logic [15:0] rdw_exp;
  logic [15:0] pc_rd_exp;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1; src_sel = 0; dst_sel = 0; wr_sel = 0; wr_data = 0; idle_a();
    b_rst = 1; b_src_sel = 0; b_dst_sel = 0; b_wr_sel = 0; b_wr_data = 0;
    b_wr_en = 0; b_pc_inc = 0; b_sp_inc = 0; b_sp_dec = 0; b_out_en = 0;

    // Reset state
    tick();
    chk("rst_src", 32'(src), 32'h0);
    chk("rst_dst", 32'(dst), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_ovld", 32'(out_valid), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_sp", 32'(sp), 32'hFFFF);

    rst = 0; src_sel = 0; dst_sel = 1;
    tick();
    chk("rd_src_r0", 32'(src), 32'h0000);
    chk("rd_dst_sp", 32'(dst), 32'hFFFF);
    chk("rd_ovld0", 32'(out_valid), 32'h0);

    // Write R3, then transfer it out
    wr_en = 1; wr_sel = 3; wr_data = 16'hA5A5;
    tick();
    idle_a(); src_sel = 3; out_en = 1;
    tick();
    chk("xfer_src", 32'(src), 32'hA5A5);
    chk("xfer_out", 32'(out), 32'hA5A5);
    chk("xfer_ovld", 32'(out_valid), 32'h1);
    out_en = 0; src_sel = 0;
    tick();
    chk("hold_ovld", 32'(out_valid), 32'h0);
    chk("hold_out", 32'(out), 32'hA5A5);

    // PC wrap and jump priority
    wr_en = 1; wr_sel = 0; wr_data = 16'hFFFE;
    tick();
    chk("pc_load", 32'(pc), 32'hFFFE);
    idle_a(); pc_inc = 1;
    tick(); chk("pc_inc1", 32'(pc), 32'hFFFF);
    tick(); chk("pc_wrap", 32'(pc), 32'h0000);
    tick(); chk("pc_inc3", 32'(pc), 32'h0001);
    wr_en = 1; wr_sel = 0; wr_data = 16'h0100;
    tick(); chk("pc_jump", 32'(pc), 32'h0100);
    idle_a();

    // SP ops
    sp_dec = 1;
    tick(); chk("sp_dec", 32'(sp), 32'hFFFE);
    sp_inc = 1;
    tick(); chk("sp_both", 32'(sp), 32'hFFFE);
    idle_a(); wr_en = 1; wr_sel = 1; wr_data = 16'hFFFF;
    tick(); chk("sp_load", 32'(sp), 32'hFFFF);
    idle_a(); sp_inc = 1;
    tick(); chk("sp_wrap", 32'(sp), 32'h0000);
    idle_a(); sp_dec = 1;
    tick(); chk("sp_dec_wrap", 32'(sp), 32'hFFFF);
    wr_en = 1; wr_sel = 1; wr_data = 16'h4000;
    tick(); chk("sp_wr_prio", 32'(sp), 32'h4000);
    idle_a();

    // Independent updates in one cycle
    pc_inc = 1; sp_dec = 1; wr_en = 1; wr_sel = 4; wr_data = 16'h7777;
    tick();
    chk("ind_pc", 32'(pc), 32'h0101);
    chk("ind_sp", 32'(sp), 32'h3FFF);
    idle_a(); dst_sel = 4;
    tick();
    chk("ind_r4", 32'(dst), 32'h7777);

    // Read during write
`ifdef REGFILE_BYPASS_EN
    rdw_exp   = 16'h1234;
    pc_rd_exp = 16'h0102;
`else
    rdw_exp   = 16'h0000;
    pc_rd_exp = 16'h0101;
`endif
    wr_en = 1; wr_sel = 2; wr_data = 16'h1234; src_sel = 2; out_en = 1;
    tick();
    chk("rdw_src", 32'(src), 32'(rdw_exp));
    chk("rdw_out", 32'(out), 32'(rdw_exp));
    idle_a();
    tick();
    chk("rdw_after", 32'(src), 32'h1234);
    src_sel = 0; pc_inc = 1;
    tick();
    chk("rdw_pc", 32'(src), 32'(pc_rd_exp));
    idle_a();

    // Reset overrides a concurrent write and increment
    wr_en = 1; wr_sel = 5; wr_data = 16'hBEEF; pc_inc = 1; out_en = 1; rst = 1;
    tick();
    rst = 0; idle_a(); src_sel = 5;
    chk("mrst_pc", 32'(pc), 32'h0);
    chk("mrst_sp", 32'(sp), 32'hFFFF);
    chk("mrst_ovld", 32'(out_valid), 32'h0);
    tick();
    chk("mrst_r5", 32'(src), 32'h0);

    // Wide instance: 32-bit, 16 registers
    b_rst = 0; b_wr_en = 1; b_wr_sel = 9; b_wr_data = 32'hDEADBEEF;
    tick();
    b_wr_en = 0; b_pc_inc = 1; b_sp_dec = 1; b_src_sel = 9;
    tick();
    chk("w_r9", b_src, 32'hDEADBEEF);
    chk("w_pc", b_pc, 32'h1);
    chk("w_sp", b_sp, 32'hFFFFFFFE);
    b_sp_dec = 0;
    b_wr_en = 1; b_wr_sel = 5; b_wr_data = 32'h0000BEEF; b_out_en = 1; b_rst = 1;
    tick();
    b_rst = 0; b_wr_en = 0; b_pc_inc = 0; b_out_en = 0; b_src_sel = 5; b_dst_sel = 9;
    chk("w_mrst_pc", b_pc, 32'h0);
    chk("w_mrst_sp", b_sp, 32'hFFFFFFFF);
    chk("w_mrst_ovld", 32'(b_out_valid), 32'h0);
    tick();
    chk("w_mrst_r5", b_src, 32'h0);
    chk("w_mrst_r9", b_dst, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_multi.md
Name: regfile_multi

Overview:
- Parametrised general-purpose register file for the tiny16 CPU and its wider variants.
- Provides two registered read ports (src, dst), one write port and a gated transfer port (out).
- Dedicated program-counter (PC) and stack-pointer (SP) registers, updated in place: PC increment, SP increment/decrement.
- Sits between the instruction decoder/control FSM and the ALU/bus.
- All state changes on the rising clock edge only.

Parameters:
- WIDTH, 16: data width of every register.
- DEPTH, 8: number of registers; power of two, >= 2.
- PC_IDX, 0: index of the program counter.
- SP_IDX, 1: index of the stack pointer; must differ from PC_IDX.
- SP_RESET, {WIDTH{1'b1}}: SP value after reset.
- AW (localparam) = $clog2(DEPTH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- src_sel  in  AW  source read select
- dst_sel  in  AW  destination read select
- wr_en  in  1  write strobe
- wr_sel  in  AW  write target index
- wr_data  in  WIDTH  write data
- pc_inc  in  1  increment PC by 1
- sp_inc  in  1  increment SP by 1
- sp_dec  in  1  decrement SP by 1
- out_en  in  1  load out from register[src_sel]
- src  out  WIDTH  registered read of register[src_sel]
- dst  out  WIDTH  registered read of register[dst_sel]
- out  out  WIDTH  registered transfer value
- out_valid  out  1  out holds data loaded in the previous cycle
- pc  out  WIDTH  current PC, direct from register (no added latency)
- sp  out  WIDTH  current SP, direct from register

Behaviour:
- Reset (clk, rst: synchronous, active-high):
  - all registers clear to 0, except register[SP_IDX] = SP_RESET;
  - src, dst, out clear to 0; out_valid clears to 0;
  - rst overrides every other input in the same cycle;
  - asserting rst mid-sequence discards any concurrent write or increment.
- Read latency: 1 cycle.
  - src/dst/out take the value selected at edge N and present it after edge N.
  - src and dst update every non-reset cycle.
- Transfer port (out):
  - out_en=1: out <= selected value and out_valid <= 1;
  - out_en=0: out holds its last value and out_valid <= 0;
  - out is never driven to Z.
- Write: when wr_en=1, register[wr_sel] <= wr_data at the edge.
- PC update priority:
  - wr_en with wr_sel==PC_IDX (jump) beats pc_inc;
  - otherwise pc_inc adds 1 modulo 2^WIDTH, so all-ones wraps to 0.
- SP update priority:
  - wr_en with wr_sel==SP_IDX beats sp_inc/sp_dec;
  - sp_inc and sp_dec together: SP unchanged;
  - increment/decrement are modulo 2^WIDTH (0 - 1 = all-ones).
- Independent updates: pc_inc, SP ops and a write to any other register all take effect in the same cycle.
- Read-during-write (same cycle, selected register being updated): src/dst/out capture the OLD value, unless BYPASS_EN is defined.
- pc/sp outputs always reflect the post-edge register contents.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: src, dst and out capture the register's NEXT value whenever it is updated that cycle, following the same priority rules:
  - write data;
  - PC+1 for an increment;
  - SP+/-1 for an SP op.
- Result: a read issued alongside a write returns the new data one cycle later.
- Undefined: old-value semantics as above; no extra forwarding logic is built.

Test Plan:
- Reset, defaults, then src_sel=0, dst_sel=1 -> next cycle src=0x0000, dst=0xFFFF, pc=0, sp=0xFFFF, out=0, out_valid=0.
- wr_en, wr_sel=3, wr_data=0xA5A5, then src_sel=3 with out_en=1 -> src=0xA5A5, out=0xA5A5, out_valid=1; the following cycle with out_en=0 -> out_valid=0, out holds 0xA5A5.
- PC=0xFFFE, pc_inc for 3 cycles -> 0xFFFF, 0x0000, 0x0001; same cycle pc_inc plus wr_en to PC with 0x0100 -> PC=0x0100.
- SP=0xFFFF, sp_dec -> 0xFFFE; sp_inc plus sp_dec together -> unchanged 0xFFFE; SP=0xFFFF with sp_inc -> 0x0000.
- wr_sel=2, wr_data=0x1234 with src_sel=2 in the same cycle, old R2=0 -> src=0x0000 without macro, 0x1234 with REGFILE_BYPASS_EN.
- wr_en to R5 with 0xBEEF, plus pc_inc, plus rst, all in the same cycle -> R5=0, PC=0, SP=SP_RESET, out_valid=0; repeat at WIDTH=32, DEPTH=16.
